riscv_ifetch: RTL and testbench

RISCV_IFETCH -- requirements
Module: riscv_ifetch

---
 rtl/riscv_package.sv | 18 +
 rtl/riscv_ifetch_buf.sv | 104 ++++++++++
 rtl/riscv_ifetch.sv | 157 +++++++++++++++
 tb/tb_riscv_ifetch.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_package.sv
// Shared types and constants for the instruction fetch unit.
package riscv_package;

  localparam int IFETCH_DEPTH_MAX = 4;
  localparam int IFETCH_PTR_W     = 2;

  typedef logic [1:0] ifetch_state_t;

  localparam ifetch_state_t IF_IDLE = 2'd0;
  localparam ifetch_state_t IF_REQ  = 2'd1;
  localparam ifetch_state_t IF_WAIT = 2'd2;

  // Word addresses wrap naturally at 2^30.
  function automatic logic [29:0] ifetch_next_addr(input logic [29:0] addr);
    return addr + 30'd1;
  endfunction

endpackage

// File: rtl/riscv_ifetch_buf.sv
// Tagged prefetch FIFO: DEPTH entries of {30-bit word address, 32-bit data}.
// A slot can be reserved while a prefetch is in flight so full accounts for it.
module riscv_ifetch_buf
  import riscv_package::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [29:0] push_tag,
  input  logic [31:0] push_data,
  input  logic        pop,
  input  logic        flush,
  input  logic        rsv_set,
  input  logic        rsv_clr,
  output logic [29:0] head_tag,
  output logic [31:0] head_data,
  output logic        full,
  output logic        empty
);

  localparam logic [IFETCH_PTR_W-1:0] LAST_PTR = IFETCH_PTR_W'(DEPTH - 1);
  localparam logic [IFETCH_PTR_W:0]   DEPTH_C  = (IFETCH_PTR_W + 1)'(DEPTH);

  logic [29:0]             tag_reg  [IFETCH_DEPTH_MAX];
  logic [31:0]             data_reg [IFETCH_DEPTH_MAX];
  logic [IFETCH_PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [IFETCH_PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [IFETCH_PTR_W:0]   count_reg, count_next;
  logic                    rsv_reg, rsv_next;
  logic                    push_ok, pop_ok;
  logic [IFETCH_DEPTH_MAX-1:0] wen;

  function automatic logic [IFETCH_PTR_W-1:0] ptr_inc(input logic [IFETCH_PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count_reg == '0);
  assign full      = (count_reg + {{IFETCH_PTR_W{1'b0}}, rsv_reg}) >= DEPTH_C;
  assign push_ok   = push && !flush && (count_reg < DEPTH_C);
  assign pop_ok    = pop && !flush && !empty;
  assign head_tag  = tag_reg[rd_ptr_reg];
  assign head_data = data_reg[rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < IFETCH_DEPTH_MAX; gi++) begin : g_wen
      assign wen[gi] = push_ok && (wr_ptr_reg == IFETCH_PTR_W'(gi));
    end
  endgenerate

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_ok) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (pop_ok)  rd_ptr_next = ptr_inc(rd_ptr_reg);
      case ({push_ok, pop_ok})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
    rsv_next = rsv_reg;
    if (rsv_set)      rsv_next = 1'b1;
    else if (rsv_clr) rsv_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      rsv_reg    <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      rsv_reg    <= rsv_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < IFETCH_DEPTH_MAX; i++) begin
        tag_reg[i]  <= '0;
        data_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < IFETCH_DEPTH_MAX; i++) begin
        if (wen[i]) begin
          tag_reg[i]  <= push_tag;
          data_reg[i] <= push_data;
        end
      end
    end
  end

endmodule

// File: rtl/riscv_ifetch.sv
// Instruction fetch unit: demand fetches with one outstanding memory transaction.
// Define RISCV_IFETCH_PREFETCH_EN to add the sequential prefetch buffer.
module riscv_ifetch
  import riscv_package::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [29:0] fetch_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);

  ifetch_state_t state_reg, state_next;
  logic          txn_demand_reg, txn_demand_next;
  logic          stale_reg, stale_next;
  logic [29:0]   last_addr_reg, last_addr_next;
  logic          imem_req_reg, imem_req_next;
  logic [29:0]   imem_addr_reg, imem_addr_next;
  logic [31:0]   instr_reg, instr_next;
  logic          instr_valid_reg, instr_valid_next;

  logic          fetch_act, rsp_done, demand_rsp, issue;
  logic [29:0]   issue_addr;
  logic          hit, stale_set, want_demand, want_pf;
  logic [31:0]   hit_data;

  // The core still holds fetch_req in the cycle instr_valid is shown; ignore it then.
  assign fetch_act  = fetch_req && !instr_valid_reg;
  assign rsp_done   = (state_reg == IF_WAIT) && imem_rvalid;
  assign demand_rsp = rsp_done && txn_demand_reg && !stale_reg;

`ifdef RISCV_IFETCH_PREFETCH_EN
  logic        buf_full, buf_empty, miss, pf_push, primed_reg;
  logic [29:0] head_tag;

  assign hit         = fetch_act && !buf_empty && (head_tag == fetch_addr);
  assign miss        = fetch_act && !buf_empty && (head_tag != fetch_addr);
  assign want_demand = fetch_act && (buf_empty || miss);
  assign want_pf     = primed_reg && !buf_full;
  assign pf_push     = rsp_done && !txn_demand_reg && !stale_reg && !miss;
  // A response landing in the miss cycle is simply dropped; only later ones need the flag.
  assign stale_set   = miss && ((state_reg == IF_REQ) ||
                                ((state_reg == IF_WAIT) && !imem_rvalid));

  // The prefetch stream has no meaningful base address until a demand fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     primed_reg <= 1'b0;
    else if (issue && want_demand) primed_reg <= 1'b1;
  end

  riscv_ifetch_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (pf_push),
    .push_tag (imem_addr_reg),
    .push_data(imem_rdata),
    .pop      (hit),
    .flush    (miss),
    .rsv_set  (issue && !want_demand),
    .rsv_clr  (rsp_done && !txn_demand_reg),
    .head_tag (head_tag),
    .head_data(hit_data),
    .full     (buf_full),
    .empty    (buf_empty)
  );
`else
  logic [31:0] unused_depth;
  assign unused_depth = 32'(DEPTH);
  assign hit          = 1'b0;
  assign hit_data     = '0;
  assign want_demand  = fetch_act;
  assign want_pf      = 1'b0;
  assign stale_set    = 1'b0;
`endif

  assign issue      = (state_reg == IF_IDLE) && (want_demand || want_pf);
  assign issue_addr = want_demand ? fetch_addr : ifetch_next_addr(last_addr_reg);

  always_comb begin
    state_next       = state_reg;
    txn_demand_next  = txn_demand_reg;
    last_addr_next   = last_addr_reg;
    imem_req_next    = imem_req_reg;
    imem_addr_next   = imem_addr_reg;
    instr_valid_next = demand_rsp || hit;
    instr_next       = instr_reg;
    if (hit)             instr_next = hit_data;
    else if (demand_rsp) instr_next = imem_rdata;

    stale_next = stale_reg;
    if (rsp_done)       stale_next = 1'b0;
    else if (stale_set) stale_next = 1'b1;

    case (state_reg)
      IF_IDLE: begin
        if (issue) begin
          state_next      = IF_REQ;
          imem_req_next   = 1'b1;
          imem_addr_next  = issue_addr;
          last_addr_next  = issue_addr;
          txn_demand_next = want_demand;
        end
      end
      IF_REQ: begin
        if (imem_gnt) begin
          state_next    = IF_WAIT;
          imem_req_next = 1'b0;
        end
      end
      IF_WAIT: begin
        if (imem_rvalid) state_next = IF_IDLE;
      end
      default: begin
        state_next    = IF_IDLE;
        imem_req_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IF_IDLE;
      txn_demand_reg  <= 1'b0;
      stale_reg       <= 1'b0;
      last_addr_reg   <= '0;
      imem_req_reg    <= 1'b0;
      imem_addr_reg   <= '0;
      instr_reg       <= '0;
      instr_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      txn_demand_reg  <= txn_demand_next;
      stale_reg       <= stale_next;
      last_addr_reg   <= last_addr_next;
      imem_req_reg    <= imem_req_next;
      imem_addr_reg   <= imem_addr_next;
      instr_reg       <= instr_next;
      instr_valid_reg <= instr_valid_next;
    end
  end

  assign imem_req    = imem_req_reg;
  assign imem_addr   = imem_addr_reg;
  assign instr       = instr_reg;
  assign instr_valid = instr_valid_reg;

endmodule

// File: tb/tb_riscv_ifetch.sv
// Directed bench for riscv_ifetch with a simple instruction memory model.
module tb_riscv_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic [29:0] fetch_addr = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;

  int pass_cnt = 0;
  int total_cnt = 0;

  riscv_ifetch #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .instr      (instr),
    .instr_valid(instr_valid),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: grant after gnt_delay waiting cycles, respond resp_lat cycles after grant.
  int          gnt_delay = 0;
  int          resp_lat = 1;
  int          stall_cnt = 0;
  logic        pend = 1'b0;
  int          pend_cnt = 0;
  logic [29:0] pend_addr = '0;
  logic [29:0] grant_log[$];

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a[23:0], 8'h13};
  endfunction

  assign imem_gnt = imem_req && (stall_cnt >= gnt_delay);

  always @(posedge clk) begin
    imem_rvalid <= 1'b0;
    if (imem_req && !imem_gnt) stall_cnt <= stall_cnt + 1;
    else                       stall_cnt <= 0;
    if (pend) begin
      if (pend_cnt <= 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mem_word(pend_addr);
        pend        <= 1'b0;
      end else begin
        pend_cnt <= pend_cnt - 1;
      end
    end
    if (imem_req && imem_gnt) begin
      grant_log.push_back(imem_addr);
      if (resp_lat <= 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mem_word(imem_addr);
      end else begin
        pend      <= 1'b1;
        pend_cnt  <= resp_lat - 1;
        pend_addr <= imem_addr;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] logged(input int i);
    if (grant_log.size() > i) return {2'b00, grant_log[i]};
    return 32'hFFFF_FFFF;
  endfunction

  // Called at a negedge; returns cycles until instr_valid and pulses seen incl. one idle cycle.
  task automatic do_fetch(input logic [29:0] a, output int lat, output logic [31:0] data,
                          output int pulses);
    logic got;
    got = 1'b0;
    lat = 0;
    data = '0;
    pulses = 0;
    fetch_addr = a;
    fetch_req = 1'b1;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (instr_valid) begin
        got = 1'b1;
        data = instr;
        pulses = 1;
      end
    end
    fetch_req = 1'b0;
    @(negedge clk);
    if (instr_valid) pulses++;
    $display("fetch addr=%08h latency=%0d instr=%08h pulses=%0d", a, lat, data, pulses);
  endtask

  task automatic fetch_check(input string name, input logic [29:0] a,
                             input logic [31:0] exp_data, input int exp_lat);
    int          lat, pulses;
    logic [31:0] data;
    do_fetch(a, lat, data, pulses);
    check({name, "_instr"}, 64'(data), 64'(exp_data));
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_pulses"}, 64'(pulses), 64'd1);
  endtask

  typedef struct {
    logic [29:0] addr;
    int          gnt_dly;
    logic [31:0] exp_instr;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic        stable, seen_rvalid;
    int          req_n, gnt_at;

    vecs[0] = '{30'h0000123, 0, 32'h0001_2313, 3};
    vecs[1] = '{30'h2AAAAAAA, 1, 32'hAAAA_AA13, 4};
    vecs[2] = '{30'h3FFFFFFF, 2, 32'hFFFF_FF13, 5};
    vecs[3] = '{30'h0000010, 3, 32'h0000_1013, 6};
    vecs[4] = '{30'h00ABCDE, 0, 32'h0ABC_DE13, 3};

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_outputs", {instr_valid, imem_req, imem_addr, instr}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Cold start
    fetch_check("cold_start", 30'h0, 32'h0000_0013, 3);

`ifdef RISCV_IFETCH_PREFETCH_EN
    repeat (20) @(negedge clk);
    fetch_check("seq_hit1", 30'h1, 32'h0000_0113, 1);
    fetch_check("seq_hit2", 30'h2, 32'h0000_0213, 1);
`else
    repeat (5) @(negedge clk);
    check("no_prefetch_req", 64'(imem_req), 64'd0);
`endif

    // Demand fetches with varying grant delay
    for (int i = 0; i < 5; i++) begin
      repeat (20) @(negedge clk);
      gnt_delay = vecs[i].gnt_dly;
      fetch_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_instr, vecs[i].exp_lat);
      gnt_delay = 0;
    end

    // Grant withheld for 5 cycles
    repeat (20) @(negedge clk);
    gnt_delay = 5;
    fetch_addr = 30'h155;
    fetch_req = 1'b1;
    stable = 1'b1;
    req_n = 0;
    gnt_at = 0;
    for (int k = 0; k < 40 && !instr_valid; k++) begin
      @(negedge clk);
      if (gnt_at == 0) begin
        if (imem_req) begin
          req_n++;
          if (imem_addr != 30'h155) stable = 1'b0;
          if (imem_gnt) gnt_at = req_n;
        end else if (req_n > 0) begin
          stable = 1'b0;
        end
      end
    end
    check("stall_instr", 64'(instr), 64'h0001_5513);
    fetch_req = 1'b0;
    gnt_delay = 0;
    check("stall_req_stable", 64'(stable), 64'd1);
    check("stall_grant_cycle", 64'(gnt_at), 64'd6);

`ifdef RISCV_IFETCH_PREFETCH_EN
    // Miss with a stale prefetch in flight
    repeat (20) @(negedge clk);
    grant_log.delete();
    fetch_check("flush_seed", 30'h4, 32'h0000_0413, 3);
    repeat (20) @(negedge clk);
    check("flush_pf5", 64'(logged(1)), 64'h5);
    check("flush_pf6", 64'(logged(2)), 64'h6);
    gnt_delay = 1000;
    fetch_check("flush_hit5", 30'h5, 32'h0000_0513, 1);
    check("flush_pf7_pending", {31'd0, imem_req, 2'd0, imem_addr}, {31'd0, 1'b1, 32'h7});
    gnt_delay = 0;
    fetch_check("flush_miss40", 30'h40, 32'h0000_4013, 5);
    check("flush_grant7", 64'(logged(3)), 64'h7);
    check("flush_grant40", 64'(logged(4)), 64'h40);
    repeat (20) @(negedge clk);
    fetch_check("flush_after_hit41", 30'h41, 32'h0000_4113, 1);

    // Prefetch address wrap
    repeat (20) @(negedge clk);
    grant_log.delete();
    fetch_check("wrap_seed", 30'h3FFFFFFE, 32'hFFFF_FE13, 3);
    repeat (20) @(negedge clk);
    check("wrap_pf_top", 64'(logged(1)), 64'h3FFF_FFFF);
    check("wrap_pf_zero", 64'(logged(2)), 64'h0);
    fetch_check("wrap_hit_top", 30'h3FFFFFFF, 32'hFFFF_FF13, 1);
    fetch_check("wrap_hit_zero", 30'h0, 32'h0000_0013, 1);
`endif

    // Reset in IF_WAIT with a late response
    repeat (20) @(negedge clk);
    resp_lat = 4;
    fetch_addr = 30'h77;
    fetch_req = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (imem_gnt) break;
    end
    @(negedge clk);
    rst = 1'b0;
    fetch_req = 1'b0;
    #1;
    check("rst_wait_async", {instr_valid, imem_req, imem_addr, instr}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    seen_rvalid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (imem_rvalid) seen_rvalid = 1'b1;
      check($sformatf("rst_wait_hold%0d", k), {instr_valid, imem_req, imem_addr, instr}, 64'd0);
    end
    check("rst_late_rvalid_seen", 64'(seen_rvalid), 64'd1);
    resp_lat = 1;
    fetch_check("rst_recover", 30'h500, 32'h0005_0013, 3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "timeout");
  end

endmodule
